rpn_stack_ctrl: RTL and testbench

- Sequencer for the RPN calculator datapath.
- Owns the stack pointer and drives the single-port stack RAM and the combinational ALU.
- Executes one command at a time (PUSH, POP, CLEAR, binary ALU op) under a valid/ready handshake from the key/switch front end.
- Exposes top-of-stack, depth and error status for the LED/seven-segment display logic.

---
 rtl/rpn_pkg.sv | 52 +++++
 rtl/reg_load_enable.sv | 15 +
 rtl/rpn_stack_ctrl.sv | 168 ++++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared constants for the RPN calculator: opcodes, ALU selects, sequencer
// state encodings and seven-segment patterns.
package rpn_pkg;
   localparam logic [3:0] OP_PUSH  = 4'b0001;
   localparam logic [3:0] OP_POP   = 4'b0010;
   localparam logic [3:0] OP_CLEAR = 4'b0011;
   localparam logic       OP_BIN   = 1'b1;    // cmd[3] set selects a binary op

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_MUL = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;

   localparam logic [3:0] S_CLR     = 4'd0;
   localparam logic [3:0] S_IDLE    = 4'd1;
   localparam logic [3:0] S_PUSH    = 4'd2;
   localparam logic [3:0] S_POP     = 4'd3;
   localparam logic [3:0] S_POP_TOS = 4'd4;
   localparam logic [3:0] S_RD_B    = 4'd5;
   localparam logic [3:0] S_RD_A    = 4'd6;
   localparam logic [3:0] S_LAT_A   = 4'd7;
   localparam logic [3:0] S_EXEC    = 4'd8;
   localparam logic [3:0] S_WR_RES  = 4'd9;
   localparam logic [3:0] S_ERR     = 4'd10;

   // Segment order gfedcba, active high.
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_MINUS = 7'h40;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0: hex_to_seg = 7'h3F;
         4'h1: hex_to_seg = 7'h06;
         4'h2: hex_to_seg = 7'h5B;
         4'h3: hex_to_seg = 7'h4F;
         4'h4: hex_to_seg = 7'h66;
         4'h5: hex_to_seg = 7'h6D;
         4'h6: hex_to_seg = 7'h7D;
         4'h7: hex_to_seg = 7'h07;
         4'h8: hex_to_seg = 7'h7F;
         4'h9: hex_to_seg = 7'h6F;
         4'hA: hex_to_seg = 7'h77;
         4'hB: hex_to_seg = 7'h7C;
         4'hC: hex_to_seg = 7'h39;
         4'hD: hex_to_seg = 7'h5E;
         4'hE: hex_to_seg = 7'h79;
         default: hex_to_seg = 7'h71;
      endcase
   endfunction
endpackage

// File: rtl/reg_load_enable.sv
// Register with synchronous active-low clear and load enable.
module reg_load_enable #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (!rst_n)    q <= '0;
      else if (load) q <= d;
   end
endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN stack sequencer: owns the stack pointer, sequences the single-port
// stack RAM and the combinational ALU, one command at a time.
module rpn_stack_ctrl
   import rpn_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       cmd_valid,
   input  logic [3:0] cmd,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       done,
   output logic       err,
   output logic [7:0] sp,
   output logic [7:0] tos,
   output logic [7:0] ram_addr,
   output logic       ram_wr,
   output logic [7:0] ram_wdata,
   input  logic [7:0] ram_rdata,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [7:0] alu_result
);
   localparam logic [7:0] DEPTH_W = 8'(DEPTH);
   localparam logic [7:0] LAST_W  = 8'(DEPTH - 1);

   logic [3:0] state;
   logic [7:0] clr_cnt, rd_addr, data_q, sp_d, addr_c, wdata_c;
   logic       clr_by_cmd, nop_q, sp_load, clr_last, accept, wr_c, done_c;

   assign clr_last  = (state == S_CLR) && (clr_cnt == LAST_W);
   assign cmd_ready = (state == S_IDLE) && !nop_q;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      sp_load = 1'b0;
      sp_d    = sp;
      case (state)
         S_CLR:     if (clr_last) begin sp_load = 1'b1; sp_d = 8'd0; end
         S_PUSH:    begin sp_load = 1'b1; sp_d = sp + 8'd1; end
         S_POP:     if (sp == 8'd1) begin sp_load = 1'b1; sp_d = 8'd0; end
         S_POP_TOS: begin sp_load = 1'b1; sp_d = sp - 8'd1; end
         S_WR_RES:  begin sp_load = 1'b1; sp_d = sp - 8'd1; end
         default: ;
      endcase
   end

   reg_load_enable #(.W(8)) u_sp (.clk(CLOCK_50), .rst_n(RESET_N), .load(sp_load),
                                  .d(sp_d), .q(sp));
   reg_load_enable #(.W(8)) u_b  (.clk(CLOCK_50), .rst_n(RESET_N), .load(state == S_RD_A),
                                  .d(ram_rdata), .q(alu_b));
   reg_load_enable #(.W(8)) u_a  (.clk(CLOCK_50), .rst_n(RESET_N), .load(state == S_LAT_A),
                                  .d(ram_rdata), .q(alu_a));

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state      <= S_CLR;
         clr_cnt    <= 8'd0;
         clr_by_cmd <= 1'b0;
         nop_q      <= 1'b0;
         alu_op     <= 3'd0;
         data_q     <= 8'd0;
         rd_addr    <= 8'd0;
         tos        <= 8'd0;
         err        <= 1'b0;
      end else begin
         nop_q <= 1'b0;
         case (state)
            S_CLR: begin
               if (clr_last) begin
                  state      <= S_IDLE;
                  tos        <= 8'd0;
                  err        <= 1'b0;
                  clr_by_cmd <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + 8'd1;
               end
            end
            S_IDLE: if (accept) begin
               alu_op <= cmd[2:0];
               data_q <= cmd_data;
               if (cmd[3] == OP_BIN) begin
                  state <= (sp < 8'd2) ? S_ERR : S_RD_B;
               end else begin
                  case (cmd)
                     OP_PUSH:  state <= (sp == DEPTH_W) ? S_ERR : S_PUSH;
                     OP_POP:   state <= (sp == 8'd0) ? S_ERR : S_POP;
                     OP_CLEAR: begin
                        state      <= S_CLR;
                        clr_cnt    <= 8'd0;
                        clr_by_cmd <= 1'b1;
                     end
                     default:  nop_q <= 1'b1;
                  endcase
               end
            end
            S_PUSH: begin
               tos   <= data_q;
               state <= S_IDLE;
            end
            // sp drops on the done edge, so a two-cycle pop decrements in POP_TOS
            S_POP: begin
               if (sp == 8'd1) begin
                  tos   <= 8'd0;
                  state <= S_IDLE;
               end else begin
                  rd_addr <= sp - 8'd2;
                  state   <= S_POP_TOS;
               end
            end
            S_POP_TOS: begin
               tos   <= ram_rdata;
               state <= S_IDLE;
            end
            S_RD_B: begin
               rd_addr <= sp - 8'd1;
               state   <= S_RD_A;
            end
            S_RD_A: begin
               rd_addr <= sp - 8'd2;
               state   <= S_LAT_A;
            end
            S_LAT_A: state <= S_EXEC;
            S_EXEC:  state <= S_WR_RES;
            S_WR_RES: begin
               tos   <= alu_result;
               state <= S_IDLE;
            end
            S_ERR: begin
               err   <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state   <= S_CLR;
               clr_cnt <= 8'd0;
            end
         endcase
      end
   end

   always_comb begin
      addr_c  = rd_addr;
      wdata_c = 8'd0;
      wr_c    = 1'b0;
      case (state)
         S_CLR:    begin addr_c = clr_cnt; wr_c = 1'b1; end
         S_PUSH:   begin addr_c = sp; wdata_c = data_q; wr_c = 1'b1; end
         S_WR_RES: begin addr_c = sp - 8'd2; wdata_c = alu_result; wr_c = 1'b1; end
         S_RD_B:   addr_c = sp - 8'd1;
         S_RD_A:   addr_c = sp - 8'd2;
         S_POP:    if (sp > 8'd1) addr_c = sp - 8'd2;
         default: ;
      endcase
   end

   assign done_c = nop_q || (state == S_PUSH) || (state == S_POP && sp == 8'd1) ||
                   (state == S_POP_TOS) || (state == S_WR_RES) || (state == S_ERR) ||
                   (clr_last && clr_by_cmd);

   // Reset forces the combinational outputs low even though state sits in CLR.
   assign done      = RESET_N && done_c;
   assign ram_wr    = RESET_N && wr_c;
   assign ram_addr  = RESET_N ? addr_c : 8'd0;
   assign ram_wdata = RESET_N ? wdata_c : 8'd0;
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl with a behavioural stack RAM and ALU.
module tb_rpn_stack_ctrl;
   logic       CLOCK_50 = 1'b0;
   logic       RESET_N;
   logic       cmd_valid;
   logic [3:0] cmd;
   logic [7:0] cmd_data;
   logic       cmd_ready, done, err, ram_wr;
   logic [7:0] sp, tos, ram_addr, ram_wdata, alu_a, alu_b, alu_result;
   logic [7:0] ram_rdata = 8'd0;
   logic [2:0] alu_op;

   logic [7:0] mem [0:255];
   int         wr_cnt = 0, done_cnt = 0;
   int         tests = 0, failed = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   rpn_stack_ctrl #(.DEPTH(16)) dut (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .cmd_valid(cmd_valid), .cmd(cmd),
      .cmd_data(cmd_data), .cmd_ready(cmd_ready), .done(done), .err(err), .sp(sp),
      .tos(tos), .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result)
   );

   always @(posedge CLOCK_50) begin
      ram_rdata <= mem[ram_addr];
      if (ram_wr) begin
         mem[ram_addr] <= ram_wdata;
         wr_cnt        <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   always_comb begin
      case (alu_op)
         3'd0: alu_result = alu_a + alu_b;
         3'd1: alu_result = alu_a - alu_b;
         3'd2: alu_result = alu_a * alu_b;
         3'd3: alu_result = alu_a & alu_b;
         3'd4: alu_result = alu_a | alu_b;
         3'd5: alu_result = alu_a ^ alu_b;
         default: alu_result = 8'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Latency n counts negedges after the accept edge; the first cycle after accept is 1.
   task automatic do_cmd(input string tag, input logic [3:0] c, input logic [7:0] d,
                         input int exp_lat);
      int lat;
      logic busy_ok;
      for (int k = 0; k < 100 && !cmd_ready; k++) begin
         @(posedge CLOCK_50); #1;
      end
      check({tag, "_ready"}, cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd = c; cmd_data = d;
      @(posedge CLOCK_50); #1;
      cmd_valid = 1'b0;
      lat = -1;
      busy_ok = 1'b1;
      for (int n = 1; n <= 64; n++) begin
         @(negedge CLOCK_50);
         if (cmd_ready) busy_ok = 1'b0;
         if (done) begin lat = n; break; end
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy"}, busy_ok, 1'b1);
      @(posedge CLOCK_50); #1;
   endtask

   task automatic clr_walk(input string tag);
      logic ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge CLOCK_50);
         if (!(ram_wr === 1'b1 && ram_addr === 8'(i) && ram_wdata === 8'd0 &&
               cmd_ready === 1'b0 && done === 1'b0)) ok = 1'b0;
      end
      check({tag, "_walk"}, ok, 1'b1);
      @(negedge CLOCK_50);
      check({tag, "_ready"}, cmd_ready, 1'b1);
      check({tag, "_sp"}, sp, 8'd0);
      check({tag, "_tos"}, tos, 8'd0);
      check({tag, "_err"}, err, 1'b0);
      @(posedge CLOCK_50); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w0, d0;
      RESET_N = 1'b0; cmd_valid = 1'b0; cmd = 4'd0; cmd_data = 8'd0;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check("rst_ctrl", {cmd_ready, done, err, ram_wr}, 4'b0000);
      check("rst_sp", sp, 8'd0);
      check("rst_tos", tos, 8'd0);
      check("rst_ram_bus", {ram_addr, ram_wdata}, 16'd0);
      check("rst_alu", {alu_a, alu_b, 5'(alu_op)}, 21'd0);
      @(posedge CLOCK_50); #1;
      RESET_N = 1'b1;
      clr_walk("rst_clr");
      check("rst_clr_no_done", done_cnt, 0);

      do_cmd("push5", 4'b0001, 8'd5, 1);
      do_cmd("push3", 4'b0001, 8'd3, 1);
      do_cmd("add", 4'b1000, 8'd0, 5);
      check("add_ram0", mem[0], 8'd8);
      check("add_sp", sp, 8'd1);
      check("add_tos", tos, 8'd8);
      check("add_operands", {alu_a, alu_b}, {8'd5, 8'd3});

      do_cmd("pop_last", 4'b0010, 8'd0, 1);
      check("pop_last_sp", sp, 8'd0);
      check("pop_last_tos", tos, 8'd0);

      do_cmd("push2", 4'b0001, 8'd2, 1);
      do_cmd("push7", 4'b0001, 8'd7, 1);
      do_cmd("sub", 4'b1001, 8'd0, 5);
      check("sub_tos_wrap", tos, 8'hFB);
      check("sub_sp", sp, 8'd1);
      check("sub_ram0", mem[0], 8'hFB);
      do_cmd("pop_sub", 4'b0010, 8'd0, 1);
      check("pop_sub_sp_tos", {sp, tos}, 16'd0);

      w0 = wr_cnt;
      do_cmd("pop_empty", 4'b0010, 8'd0, 1);
      check("pop_empty_err", err, 1'b1);
      check("pop_empty_sp", sp, 8'd0);
      check("pop_empty_nowr", wr_cnt, w0);
      do_cmd("push9", 4'b0001, 8'd9, 1);
      w0 = wr_cnt;
      do_cmd("add_short", 4'b1000, 8'd0, 1);
      check("add_short_err", err, 1'b1);
      check("add_short_sp_tos", {sp, tos}, {8'd1, 8'd9});
      check("add_short_nowr", wr_cnt, w0);

      do_cmd("nop", 4'b0000, 8'd0, 1);
      check("nop_state", {sp, tos, 7'd0, err}, {8'd1, 8'd9, 8'd1});

      do_cmd("clear", 4'b0011, 8'd0, 16);
      check("clear_err", err, 1'b0);
      check("clear_sp_tos", {sp, tos}, 16'd0);
      check("clear_ram0", mem[0], 8'd0);

      for (int k = 1; k <= 16; k++) do_cmd("push_fill", 4'b0001, 8'(k), 1);
      check("fill_sp", sp, 8'd16);
      check("fill_tos", tos, 8'h10);
      check("fill_err", err, 1'b0);
      w0 = wr_cnt;
      do_cmd("push_full", 4'b0001, 8'h11, 1);
      check("push_full_err", err, 1'b1);
      check("push_full_sp_tos", {sp, tos}, {8'd16, 8'h10});
      check("push_full_nowr", wr_cnt, w0);
      do_cmd("pop_full", 4'b0010, 8'd0, 2);
      check("pop_full_tos", tos, 8'h0F);
      check("pop_full_sp", sp, 8'd15);

      // MUL interrupted by reset during its EXEC cycle (4th cycle after accept).
      cmd_valid = 1'b1; cmd = 4'b1010; cmd_data = 8'd0;
      @(posedge CLOCK_50); #1;
      cmd_valid = 1'b0;
      d0 = done_cnt; w0 = wr_cnt;
      repeat (4) @(negedge CLOCK_50);
      check("mul_exec_quiet", {done, ram_wr}, 2'b00);
      RESET_N = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #1;
      RESET_N = 1'b1;
      clr_walk("mul_rst_clr");
      check("mul_rst_no_done", done_cnt, d0);
      check("mul_rst_writes", wr_cnt, w0 + 16);
      check("mul_rst_ram13", mem[13], 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
